// File: rtl/seg_share_arbiter.sv
// Round-robin share of one registered hex-to-7-segment display among three requesters.
// Optional build macro SEG_ACTIVE_LOW_EN inverts every seg value for common-anode displays.
module seg_share_arbiter #(
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [3:0] val0,
    input  logic [3:0] val1,
    input  logic [3:0] val2,
    output logic [6:0] seg,
    output logic [2:0] gnt,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] SEG_BLANK = 7'h7F;
`else
    localparam logic [6:0] SEG_BLANK = 7'h00;
`endif

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [1:0]       rr_last;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       c1, c2;
    logic [1:0]       win;
    logic             win_vld;
    logic [3:0]       win_val;
    logic [2:0]       win_oh;

    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
            4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
            4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
            4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
        endcase
`ifdef SEG_ACTIVE_LOW_EN
        return ~s;
`else
        return s;
`endif
    endfunction

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order rr_last+1, rr_last+2, rr_last (mod 3)
    always_comb begin
        c1      = next_idx(rr_last);
        c2      = next_idx(c1);
        win     = 2'd0;
        win_vld = 1'b0;
        if (req[c1]) begin
            win = c1;  win_vld = 1'b1;
        end else if (req[c2]) begin
            win = c2;  win_vld = 1'b1;
        end else if (req[rr_last]) begin
            win = rr_last;  win_vld = 1'b1;
        end
        case (win)
            2'd0:    win_val = val0;
            2'd1:    win_val = val1;
            default: win_val = val2;
        endcase
        win_oh = 3'b001 << win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_last <= 2'd2;
            cnt     <= '0;
            seg     <= SEG_BLANK;
            gnt     <= 3'b000;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    seg  <= SEG_BLANK;
                    gnt  <= 3'b000;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (win_vld) begin
                        seg     <= hex2seg(win_val);
                        gnt     <= win_oh;
                        busy    <= 1'b1;
                        cnt     <= CNT_LOAD;
                        rr_last <= win;
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    // gnt is one-hot of the current owner, so this tests req[owner]
                    if (cnt == '0 || (req & gnt) == 3'b000) begin
                        seg   <= SEG_BLANK;
                        gnt   <= 3'b000;
                        done  <= 1'b1;
                        state <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_share_arbiter.sv
// Directed self-checking bench for seg_share_arbiter with HOLD_CYCLES=4.
module tb_seg_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [3:0] val0, val1, val2;
    logic [6:0] seg;
    logic [2:0] gnt;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_share_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .val0 (val0),
        .val1 (val1),
        .val2 (val2),
        .seg  (seg),
        .gnt  (gnt),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] es(input logic [6:0] v);
`ifdef SEG_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [6:0] es_v, input logic [2:0] eg,
                           input logic eb, input logic ed);
        chk({tag, ".seg"}, seg, es_v);
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".busy"}, busy, eb);
        chk({tag, ".done"}, done, ed);
    endtask

    task automatic wait_gnt();
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != 3'b000) begin
                seen = 1;
                break;
            end
        end
        chk("wait_gnt_timeout", seen, 1);
    endtask

    initial begin
        logic [6:0] blank;
        blank = es(7'h00);
        req = 3'b000; val0 = 4'h0; val1 = 4'h0; val2 = 4'h0;
        rst_n = 1'b0;

        // reset state before any clock edge
        #2;
        chk_all("reset", blank, 3'b000, 1'b0, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk_all("idle", blank, 3'b000, 1'b0, 1'b0);

        // single requester: dwell of 4, gap, idle, regrant
        val0 = 4'h5; req = 3'b001;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all($sformatf("single.show%0d", i), es(7'h6D), 3'b001, 1'b1, 1'b0);
        end
        tick();
        chk_all("single.gap", blank, 3'b000, 1'b1, 1'b1);
        tick();
        chk_all("single.idle", blank, 3'b000, 1'b0, 1'b0);
        tick();
        chk_all("single.regrant", es(7'h6D), 3'b001, 1'b1, 1'b0);

        // asynchronous reset in the middle of SHOW
        #2 rst_n = 1'b0;
        #1;
        chk_all("midreset", blank, 3'b000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        // all requesting: rotation restarts from requester 0
        req = 3'b111; val0 = 4'h1; val1 = 4'h2; val2 = 4'h3;
        for (int n = 1; n <= 19; n++) begin
            int p, idx;
            logic [6:0] rs [3];
            rs[0] = 7'h06; rs[1] = 7'h5B; rs[2] = 7'h4F;
            tick();
            p   = (n - 1) % 6;
            idx = ((n - 1) / 6) % 3;
            if (p < 4)
                chk_all($sformatf("rr.n%0d", n), es(rs[idx]), 3'(1 << idx), 1'b1, 1'b0);
            else
                chk_all($sformatf("rr.n%0d", n), blank, 3'b000, p == 4, p == 4);
        end

        // drain, then early abort on requester 1
        req = 3'b000;
        tick(); tick();
        req = 3'b010; val1 = 4'hA;
        tick();
        chk_all("abort.show1", es(7'h77), 3'b010, 1'b1, 1'b0);
        tick();
        chk_all("abort.show2", es(7'h77), 3'b010, 1'b1, 1'b0);
        req = 3'b000;
        tick();
        chk_all("abort.gap", blank, 3'b000, 1'b1, 1'b1);
        tick();
        chk_all("abort.idle", blank, 3'b000, 1'b0, 1'b0);
        tick();
        chk_all("abort.idle2", blank, 3'b000, 1'b0, 1'b0);

        // value latched during SHOW
        req = 3'b100; val2 = 4'hC;
        tick();
        chk_all("latch.show0", es(7'h39), 3'b100, 1'b1, 1'b0);
        val2 = 4'h8;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_all($sformatf("latch.show%0d", i), es(7'h39), 3'b100, 1'b1, 1'b0);
        end
        tick();
        chk_all("latch.gap", blank, 3'b000, 1'b1, 1'b1);
        tick(); tick();
        chk_all("latch.regrant", es(7'h7F), 3'b100, 1'b1, 1'b0);
        req = 3'b000;
        tick(); tick();

        // full decode table through requester 0
        for (int v = 0; v < 16; v++) begin
            val0 = 4'(v);
            req  = 3'b001;
            wait_gnt();
            chk($sformatf("decode.%0h", v), seg, es(tbl[v]));
            req = 3'b000;
            tick(); tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_share_arbiter.md
Name: seg_share_arbiter

Overview:
Round-robin scheduler that shares one registered hex-to-seven-segment decoder/display among three requesters. Each requester presents a 4-bit value and a request line. The winner's value is latched and shown for a fixed dwell, followed by a one-cycle blank gap before the next grant. Sits between the switch/input logic and the 7-bit segment output of the top level.

Parameters:
HOLD_CYCLES, 8, dwell length in clock cycles of the SHOW state (legal range 1..255)
CNT_W, 8, width of the dwell counter (must hold HOLD_CYCLES-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  3  request lines, req[i] belongs to requester i
val0  input  4  hex value of requester 0
val1  input  4  hex value of requester 1
val2  input  4  hex value of requester 2
seg  output  7  segment drive, seg[0]=a … seg[6]=g, active high
gnt  output  3  one-hot grant, registered
busy  output  1  high in SHOW and GAP
done  output  1  one-cycle pulse on entry to GAP

Behaviour:
- All outputs are registered. Reset is asynchronous, active-low, and one clock drives the block.
- Reset values: seg=7'h00, gnt=3'b000, busy=0, done=0, state=IDLE, rr_last=2 (requester 0 wins first), counter=0.
- IDLE state:
  - Outputs are blank.
  - If any req bit is high at edge k, the winner is the first requester with req set, searching rr_last+1, rr_last+2, rr_last+3 (mod 3).
  - At edge k: gnt=one-hot(winner), the winner's value is latched, seg=decode(value), busy=1, counter=HOLD_CYCLES-1, rr_last=winner, state→SHOW.
- SHOW state:
  - seg and gnt stay stable.
  - Counter decrements each cycle. SHOW lasts exactly HOLD_CYCLES cycles.
  - Val changes during SHOW are ignored because the value is latched.
- SHOW exit: leave SHOW when the counter is 0, or when req[granted] is low at an edge (early abort). At that edge: seg=blank, gnt=0, done=1, state→GAP.
- GAP state: lasts exactly one cycle. busy=1, done returns to 0. Next state is IDLE, which can re-arbitrate on the following edge. A new grant therefore appears at the earliest 2 cycles after the SHOW exit.
- Decode table (hex digit → seg, active high):
  - 0:3F, 1:06, 2:5B, 3:4F
  - 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C
  - C:39, d:5E, E:79, F:71
- Simultaneous requests: strict rotation; no requester is granted twice while another waits.
- Single requester held high: it is regranted every HOLD_CYCLES+2 cycles.
- Reset mid-SHOW: outputs clear immediately (asynchronous) and rotation restarts from requester 0.
- HOLD_CYCLES=1: SHOW lasts one cycle.

Optional Feature:
SEG_ACTIVE_LOW_EN
- Defined: seg drives common-anode displays. Every seg value is bitwise inverted, including blank (7'h7F) and the reset value (7'h7F).
- Undefined: active-high encoding exactly as in the table.
- Arbitration, timing, gnt, busy and done are identical in both builds.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle → seg=00, gnt=000, busy=0 with no clock edge required.
- Single requester (HOLD_CYCLES=4): req=001, val0=4'h5 → gnt=001 and seg=6D for exactly 4 cycles, then one blank cycle with done=1, then regrant.
- All requesting (HOLD_CYCLES=4): req=111, val0=1, val1=2, val2=3 → seg sequence 06, 00, 5B, 00, 4F, 00, 06; gnt 001→010→100→001; each dwell 4 cycles.
- Early abort: req=010, val1=A, req dropped to 000 on cycle 2 of SHOW → seg blanks and done pulses on the next edge, then the block idles with gnt=000.
- Value latch: during SHOW of val2=4'hC (seg=39), change val2 to 4'h8 → seg stays 39 until dwell end.
- Optional build with SEG_ACTIVE_LOW_EN: req=001, val0=0 → seg=40 during SHOW, 7F when blank/reset.
